// File: rtl/command_ascii.sv
// Receive-side ASCII command parser: turns "K<hex>\r", "P<hex>\r" and "S\r" lines into key/text/start commands.
// Latency: cmd_valid and err appear one cycle after the accepted terminator/offending byte; echo one cycle after acceptance.
// Backpressure: require drops while a decoded command waits in HOLD; bytes offered then are not consumed.
// Optional feature macro: COMMAND_ASCII_ECHO_EN builds the echo register (otherwise echo outputs are tied low).

module command_ascii #(
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data,
    input  logic                  valid,
    output logic                  require,
    output logic [1:0]            cmd_type,
    output logic [DATA_WIDTH-1:0] cmd_payload,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            echo_data,
    output logic                  echo_valid
);

    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] DIG_LAST = CW'(DIGITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Parser states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_TERM    = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    // Command and error encodings as seen by the consumer
    localparam logic [1:0] T_KEY   = 2'd0;
    localparam logic [1:0] T_TEXT  = 2'd1;
    localparam logic [1:0] T_START = 2'd2;

    localparam logic [1:0] E_CHAR    = 2'd1;
    localparam logic [1:0] E_LENGTH  = 2'd2;
    localparam logic [1:0] E_TIMEOUT = 2'd3;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DATA_WIDTH-1:0] payload_q;
    logic [CW-1:0]         dig_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [1:0]            type_q;
    logic [1:0]            type_nxt;
    logic                  err_q;
    logic [1:0]            err_code_q;

    logic                  accept;
    logic                  in_line;
    logic                  tmo_hit;
    logic                  is_hex;
    logic [3:0]            nibble;
    logic                  is_term;
    logic                  is_space;
    logic                  is_key;
    logic                  is_text;
    logic                  is_start;

    logic                  err_set;
    logic [1:0]            err_code_nxt;
    logic                  clr_payload;
    logic                  shift_en;

    assign require   = (state != S_HOLD);
    assign accept    = valid & require;
    assign cmd_valid = (state == S_HOLD);
    assign cmd_type  = type_q;
    // START carries no payload; the payload register keeps the last K/P value underneath
    assign cmd_payload = (type_q == T_START) ? '0 : payload_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    // The idle watchdog only matters while a line is partially received
    assign in_line = (state == S_PAYLOAD) || (state == S_TERM) || (state == S_FLUSH);
    assign tmo_hit = in_line && (tmo_cnt == TMO_LAST);

    // Classify the incoming byte; letters are matched case-insensitively
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data[3:0];
        end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end
        is_term  = (data == 8'h0d) || (data == 8'h0a);
        is_space = (data == 8'h20);
        is_key   = (data == 8'h4b) || (data == 8'h6b);
        is_text  = (data == 8'h50) || (data == 8'h70);
        is_start = (data == 8'h53) || (data == 8'h73);
    end

    // Line grammar: next state, error reporting and payload control
    always_comb begin
        state_nxt    = state;
        type_nxt     = type_q;
        err_set      = 1'b0;
        err_code_nxt = err_code_q;
        clr_payload  = 1'b0;
        shift_en     = 1'b0;
        if (state == S_HOLD) begin
            if (cmd_ready) begin
                state_nxt = S_IDLE;
            end
        end else if (accept) begin
            // an accepted byte always wins over a watchdog expiry in the same cycle
            case (state)
                S_IDLE: begin
                    if (is_key || is_text) begin
                        state_nxt   = S_PAYLOAD;
                        clr_payload = 1'b1;
                        type_nxt    = is_key ? T_KEY : T_TEXT;
                    end else if (is_start) begin
                        state_nxt = S_TERM;
                        type_nxt  = T_START;
                    end else if (!(is_space || is_term)) begin
                        err_set      = 1'b1;
                        err_code_nxt = E_CHAR;
                        state_nxt    = S_FLUSH;
                    end
                end
                S_PAYLOAD: begin
                    if (is_hex) begin
                        shift_en = 1'b1;
                        if (dig_cnt == DIG_LAST) begin
                            state_nxt = S_TERM;
                        end
                    end else if (is_term) begin
                        err_set      = 1'b1;
                        err_code_nxt = E_LENGTH;
                        state_nxt    = S_IDLE;
                    end else if (!is_space) begin
                        err_set      = 1'b1;
                        err_code_nxt = E_CHAR;
                        state_nxt    = S_FLUSH;
                    end
                end
                S_TERM: begin
                    if (is_term) begin
                        state_nxt = S_HOLD;
                    end else begin
                        // an extra hex digit means the value was too long
                        err_set      = 1'b1;
                        err_code_nxt = is_hex ? E_LENGTH : E_CHAR;
                        state_nxt    = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (is_term) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            // a line already being flushed has been reported once; just abandon it
            if (state != S_FLUSH) begin
                err_set      = 1'b1;
                err_code_nxt = E_TIMEOUT;
            end
            state_nxt = S_IDLE;
        end
    end

    // State and command type registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            type_q <= T_KEY;
        end else begin
            state  <= state_nxt;
            type_q <= type_nxt;
        end
    end

    // Payload shift register and digit counter; first digit lands in the MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            dig_cnt   <= '0;
        end else if (clr_payload) begin
            payload_q <= '0;
            dig_cnt   <= '0;
        end else if (shift_en) begin
            payload_q <= {payload_q[DATA_WIDTH-5:0], nibble};
            dig_cnt   <= dig_cnt + CW'(1);
        end
    end

    // Mid-line idle watchdog, restarted by every accepted byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept || tmo_hit || !in_line) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Error pulse with a sticky code that survives until the next error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            err_q <= err_set;
            if (err_set) begin
                err_code_q <= err_code_nxt;
            end
        end
    end

`ifdef COMMAND_ASCII_ECHO_EN
    logic [7:0] echo_data_q;
    logic       echo_valid_q;

    // Echo every consumed byte one cycle later; downstream may drop it when busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'h00;
        end else begin
            echo_valid_q <= accept;
            if (accept) begin
                echo_data_q <= data;
            end
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
`else
    assign echo_valid = 1'b0;
    assign echo_data  = 8'h00;
`endif

endmodule

// File: tb/tb_command_ascii.sv
// Bench for command_ascii: line-level reference model checked every cycle plus literal spot checks.
// Runs with a 100-cycle watchdog so the timeout path is reachable quickly.
// Input bytes are offered with valid and held until require lets them through.

module tb_command_ascii;

    localparam int DW  = 128;
    localparam int DIG = DW / 4;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          valid = 1'b0;
    logic          require;
    logic [1:0]    cmd_type;
    logic [DW-1:0] cmd_payload;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    echo_data;
    logic          echo_valid;

    int  vectors = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;

    command_ascii #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .require(require),
        .cmd_type(cmd_type), .cmd_payload(cmd_payload), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .err(err), .err_code(err_code),
        .echo_data(echo_data), .echo_valid(echo_valid)
    );

    always #5 clk = ~clk;

    // Reference model: what the line seen so far implies about the outputs
    typedef struct packed {
        logic          pending;   // a complete command awaits the consumer
        logic          open;      // command letter seen, line not finished
        logic          flush;     // line already rejected, skipping to terminator
        logic          is_start;
        logic [7:0]    ndig;
        logic [DW-1:0] val;
        logic [DW-1:0] pay;
        logic [1:0]    ltype;
        logic [1:0]    code;
        logic          err;
        logic          ev;
        logic [7:0]    ed;
        logic [31:0]   idle;
    } mstate_t;

    mstate_t m;

    function automatic bit hex_ok(logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hex_val(logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    function automatic mstate_t next_m(mstate_t s, logic v, logic [7:0] d, logic rdy);
        mstate_t n;
        logic [7:0] up;
        bit term;
        n = s;
        n.err = 1'b0;
        n.ev = 1'b0;
        up = (d >= "a" && d <= "z") ? d - 8'd32 : d;
        term = (d == 8'h0d) || (d == 8'h0a);
        if (s.pending) begin
            if (rdy) n.pending = 1'b0;
        end else if (v) begin
            n.idle = 0;
`ifdef COMMAND_ASCII_ECHO_EN
            n.ev = 1'b1;
            n.ed = d;
`endif
            if (s.flush) begin
                if (term) n.flush = 1'b0;
            end else if (!s.open) begin
                if (up == "K" || up == "P") begin
                    n.open = 1'b1; n.is_start = 1'b0; n.ndig = 0; n.val = '0;
                    n.ltype = (up == "K") ? 2'd0 : 2'd1;
                end else if (up == "S") begin
                    n.open = 1'b1; n.is_start = 1'b1; n.ltype = 2'd2;
                end else if (!(d == " " || term)) begin
                    n.err = 1'b1; n.code = 2'd1; n.flush = 1'b1;
                end
            end else if (!s.is_start && s.ndig < DIG) begin
                if (hex_ok(d)) begin
                    n.val = s.val * 16 + DW'(hex_val(d));
                    n.ndig = s.ndig + 1;
                end else if (term) begin
                    n.err = 1'b1; n.code = 2'd2; n.open = 1'b0;
                end else if (d != " ") begin
                    n.err = 1'b1; n.code = 2'd1; n.open = 1'b0; n.flush = 1'b1;
                end
            end else begin
                n.open = 1'b0;
                if (term) begin
                    n.pending = 1'b1;
                    n.pay = s.is_start ? '0 : s.val;
                end else begin
                    n.err = 1'b1; n.flush = 1'b1;
                    n.code = hex_ok(d) ? 2'd2 : 2'd1;
                end
            end
        end else if (s.open || s.flush) begin
            if (s.idle == TO - 1) begin
                if (!s.flush) begin n.err = 1'b1; n.code = 2'd3; end
                n.open = 1'b0; n.flush = 1'b0; n.idle = 0;
            end else begin
                n.idle = s.idle + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= next_m(m, valid, data, cmd_ready);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("require", DW'(require), DW'(!m.pending));
            check("cmd_valid", DW'(cmd_valid), DW'(m.pending));
            check("err", DW'(err), DW'(m.err));
            check("err_code", DW'(err_code), DW'(m.code));
            check("echo_valid", DW'(echo_valid), DW'(m.ev));
            check("echo_data", DW'(echo_data), DW'(m.ed));
            if (m.pending) begin
                check("cmd_type", DW'(cmd_type), DW'(m.ltype));
                check("cmd_payload", cmd_payload, m.pay);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        data = b;
        valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = require;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (!ok) begin
            vectors++;
            fails++;
            $display("FAIL send_byte: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    string d32, d31;
    int    wait_n;

    initial begin
        d32 = "0123456789abcdef0123456789ABCDEF";
        d31 = d32.substr(0, 30);

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        idle_cycles(3);
        check("rst_require", DW'(require), DW'(1));
        check("rst_cmd_valid", DW'(cmd_valid), DW'(0));
        check("rst_cmd_type", DW'(cmd_type), DW'(0));
        check("rst_payload", cmd_payload, '0);
        check("rst_err_code", DW'(err_code), DW'(0));
        rst_n = 1'b1;
        idle_cycles(2);

        // key line held by a stalled consumer
        cmd_ready = 1'b0;
        send_str("K000102030405060708090A0B0C0D0E0F\r");
        idle_cycles(3);
        check("t1_require_held", DW'(require), DW'(0));
        check("t1_type", DW'(cmd_type), DW'(0));
        check("t1_payload", cmd_payload, 128'h000102030405060708090a0b0c0d0e0f);
        cmd_ready = 1'b1;
        idle_cycles(1);
        check("t1_released", DW'(require), DW'(1));

        // lowercase text line with spaces and LF
        cmd_ready = 1'b0;
        send_str("p3243f6a8 885a308d 313198a2 e0370734\n");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_payload_stable", cmd_payload, 128'h3243f6a8885a308d313198a2e0370734);
        end
        check("t2_type", DW'(cmd_type), DW'(1));
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        idle_cycles(1);
        check("t2_idle_after_ready", DW'(cmd_valid), DW'(0));

        // bad character mid-payload, then a start command
        send_str("\nK12G");
        check("t3_err_pulse", DW'(err), DW'(1));
        check("t3_err_code", DW'(err_code), DW'(1));
        send_str("9\r");
        check("t3_no_cmd", DW'(cmd_valid), DW'(0));
        send_str("s\r");
        check("t3_start_valid", DW'(cmd_valid), DW'(1));
        check("t3_start_type", DW'(cmd_type), DW'(2));
        check("t3_start_payload", cmd_payload, '0);

        // unknown command letter
        send_str("x");
        check("t3_unknown_code", DW'(err_code), DW'(1));
        send_str("zz\r");

        // short and long payloads
        send_str({"P", d31, "\r"});
        check("t4_short_err", DW'(err), DW'(1));
        check("t4_short_code", DW'(err_code), DW'(2));
        send_str({"P", d32, "F"});
        check("t4_long_err", DW'(err), DW'(1));
        check("t4_long_code", DW'(err_code), DW'(2));
        send_str("12 q\r");
        send_str({"K", d32, "\r"});
        check("t4_recover_valid", DW'(cmd_valid), DW'(1));
        check("t4_recover_payload", cmd_payload, 128'h0123456789abcdef0123456789abcdef);

        // watchdog mid-line
        send_str("K12");
        wait_n = 0;
        for (int n = 1; n <= 150 && wait_n == 0; n++) begin
            @(posedge clk); #1;
            if (err) wait_n = n;
        end
        check("t5_timeout_cycles", DW'(wait_n), DW'(100));
        check("t5_timeout_code", DW'(err_code), DW'(3));
        send_str("S\r");
        check("t5_idle_after_timeout", DW'(cmd_type), DW'(2));

        // watchdog while flushing stays quiet
        send_str("K1Z");
        idle_cycles(120);
        send_str("S\r");
        check("t5_flush_timeout_idle", DW'(cmd_valid), DW'(1));

        // reset in the middle of a line
        send_str("P12");
        rst_n = 1'b0;
        #1;
        check("t5_rst_require", DW'(require), DW'(1));
        check("t5_rst_err_code", DW'(err_code), DW'(0));
        check("t5_rst_type", DW'(cmd_type), DW'(0));
        check("t5_rst_payload", cmd_payload, '0);
        check("t5_rst_echo", DW'(echo_valid), DW'(0));
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);

        // echo path
        send_str("S");
`ifdef COMMAND_ASCII_ECHO_EN
        check("t6_echo_s", DW'({echo_valid, echo_data}), DW'({1'b1, 8'h53}));
`else
        check("t6_echo_off", DW'(echo_valid), DW'(0));
`endif
        send_str("\r");
`ifdef COMMAND_ASCII_ECHO_EN
        check("t6_echo_cr", DW'({echo_valid, echo_data}), DW'({1'b1, 8'h0d}));
`else
        check("t6_echo_off_cr", DW'(echo_valid), DW'(0));
`endif
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
